serial_port_responder: RTL and testbench

//  Device-side end of the processor byte-serial interface: accepts bytes the processor writes
//  (wren/data) and supplies bytes it reads (valid/rden). Writes are buffered in a TX FIFO and

---
 rtl/serial_pkg.sv | 21 ++
 rtl/serial_fifo.sv | 54 +++++
 rtl/serial_port_responder.sv | 262 ++++++++++++++++++++++++++
 tb/tb_serial_port_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the byte-serial responder: FSM encodings, UART
// framing constants and a ceil-log2 helper used to size counters/pointers.
package serial_pkg;

  // TX and RX FSM state encodings (shared by both machines)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam int UART_DATA_BITS = 8;

  // Ceil(log2(v)); callers only use v >= 2
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_fifo.sv
// Synchronous show-ahead FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module serial_fifo
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push_ok;
  logic             w_pop_ok;

  // Full/empty are evaluated on the current pointers, so a push into a full
  // FIFO is dropped even if a pop happens in the same cycle, and a pop from
  // an empty FIFO is ignored even if a push happens in the same cycle.
  assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign empty     = (r_wptr == r_rptr);
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  // Head reads as zero while empty so the consumer never sees stale data
  assign head = empty ? '0 : r_mem[r_rptr[AW-1:0]];

  // Pointer update; the extra MSB makes them wrap modulo 2*DEPTH
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks the head
  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/serial_port_responder.sv
// Device side of the processor byte-serial interface. Processor writes go
// through a TX FIFO into a UART 8N1 transmitter; the UART RX line is
// synchronized, deserialized and queued in an RX FIFO for processor reads.
// Optional feature macro: SERIAL_LOOPBACK_EN (adds loopback_in, which routes
// the internal TX line into the receiver and parks uart_tx_out high).
module serial_port_responder
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clock,
  input  logic       reset,
`ifdef SERIAL_LOOPBACK_EN
  input  logic       loopback_in,
`endif
  input  logic [7:0] serial_wdata_in,
  input  logic       serial_wren_in,
  output logic       serial_ready_out,
  input  logic       serial_rden_in,
  output logic [7:0] serial_rdata_out,
  output logic       serial_valid_out,
  input  logic       uart_rx_in,
  output logic       uart_tx_out,
  output logic       tx_overflow_out,
  output logic       rx_overrun_out,
  output logic       rx_frame_err_out
);

  localparam int             BW        = clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]  BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]     BIT_LAST  = 3'(UART_DATA_BITS - 1);

  // TX path
  logic       w_tx_full;
  logic       w_tx_empty;
  logic [7:0] w_tx_head;
  logic       w_tx_pop;
  logic       w_tx_baud_end;
  logic       w_tx_line;
  logic [1:0] r_tx_state;
  logic [BW-1:0] r_tx_baud;
  logic [2:0] r_tx_bit;
  logic [7:0] r_tx_shift;

  // RX path
  logic       w_rx_src;
  logic       w_rx_bit;
  logic       w_rx_full;
  logic       w_rx_empty;
  logic       w_rx_push;
  logic       w_rx_stop_smp;
  logic       w_rx_baud_end;
  logic [1:0] r_rx_sync;
  logic [1:0] r_rx_state;
  logic [BW-1:0] r_rx_baud;
  logic [2:0] r_rx_bit;
  logic [7:0] r_rx_shift;
  logic       r_rx_wait;

  // Sticky error flags
  logic r_tx_ovf;
  logic r_rx_ovr;
  logic r_rx_ferr;

  // ---------------------------------------------------------------- TX ----

  serial_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (serial_wren_in),
    .pop   (w_tx_pop),
    .din   (serial_wdata_in),
    .head  (w_tx_head),
    .full  (w_tx_full),
    .empty (w_tx_empty)
  );

  assign serial_ready_out = !w_tx_full;
  assign w_tx_baud_end    = (r_tx_baud == BAUD_LAST);

  // Pop when idle, or at the end of a stop bit so queued bytes go out with
  // no idle gap between frames.
  assign w_tx_pop = !w_tx_empty &&
                    ((r_tx_state == ST_IDLE) ||
                     (r_tx_state == ST_STOP && w_tx_baud_end));

  // Line level decoded straight from state so reset forces it high at once
  always_comb begin
    w_tx_line = 1'b1;
    case (r_tx_state)
      ST_START: w_tx_line = 1'b0;
      ST_DATA:  w_tx_line = r_tx_shift[r_tx_bit];
      default:  w_tx_line = 1'b1;
    endcase
  end

  // TX framing FSM: start bit, 8 data bits LSB-first, stop bit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tx_state <= ST_IDLE;
      r_tx_baud  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
    end else begin
      case (r_tx_state)
        ST_IDLE: begin
          r_tx_baud <= '0;
          r_tx_bit  <= '0;
          if (!w_tx_empty) begin
            r_tx_shift <= w_tx_head;
            r_tx_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_tx_baud_end) begin
            r_tx_baud  <= '0;
            r_tx_state <= ST_DATA;
          end else begin
            r_tx_baud <= r_tx_baud + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_tx_baud_end) begin
            r_tx_baud <= '0;
            if (r_tx_bit == BIT_LAST) begin
              r_tx_bit   <= '0;
              r_tx_state <= ST_STOP;
            end else begin
              r_tx_bit <= r_tx_bit + 1'b1;
            end
          end else begin
            r_tx_baud <= r_tx_baud + 1'b1;
          end
        end
        default: begin
          if (w_tx_baud_end) begin
            r_tx_baud <= '0;
            if (!w_tx_empty) begin
              r_tx_shift <= w_tx_head;
              r_tx_state <= ST_START;
            end else begin
              r_tx_state <= ST_IDLE;
            end
          end else begin
            r_tx_baud <= r_tx_baud + 1'b1;
          end
        end
      endcase
    end
  end

  // ------------------------------------------------------ loopback mux ----

`ifdef SERIAL_LOOPBACK_EN
  assign w_rx_src    = loopback_in ? w_tx_line : uart_rx_in;
  assign uart_tx_out = loopback_in ? 1'b1 : w_tx_line;
`else
  assign w_rx_src    = uart_rx_in;
  assign uart_tx_out = w_tx_line;
`endif

  // ---------------------------------------------------------------- RX ----

  // Two-flop synchronizer; resets to the idle-high level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_rx_sync <= 2'b11;
    else       r_rx_sync <= {r_rx_sync[0], w_rx_src};
  end

  assign w_rx_bit      = r_rx_sync[1];
  assign w_rx_baud_end = (r_rx_baud == BAUD_LAST);
  assign w_rx_stop_smp = (r_rx_state == ST_STOP) && !r_rx_wait && w_rx_baud_end;
  assign w_rx_push     = w_rx_stop_smp && w_rx_bit;

  // RX framing FSM; after a bad stop bit it parks in STOP until the line idles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rx_state <= ST_IDLE;
      r_rx_baud  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_wait  <= 1'b0;
    end else begin
      case (r_rx_state)
        ST_IDLE: begin
          r_rx_baud <= '0;
          r_rx_bit  <= '0;
          if (!w_rx_bit) r_rx_state <= ST_START;
        end
        ST_START: begin
          if (r_rx_baud == BAUD_HALF) begin
            r_rx_baud  <= '0;
            r_rx_state <= w_rx_bit ? ST_IDLE : ST_DATA;
          end else begin
            r_rx_baud <= r_rx_baud + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_rx_baud_end) begin
            r_rx_baud  <= '0;
            r_rx_shift <= {w_rx_bit, r_rx_shift[7:1]};
            if (r_rx_bit == BIT_LAST) begin
              r_rx_bit   <= '0;
              r_rx_state <= ST_STOP;
            end else begin
              r_rx_bit <= r_rx_bit + 1'b1;
            end
          end else begin
            r_rx_baud <= r_rx_baud + 1'b1;
          end
        end
        default: begin
          if (r_rx_wait) begin
            if (w_rx_bit) begin
              r_rx_wait  <= 1'b0;
              r_rx_state <= ST_IDLE;
            end
          end else if (w_rx_baud_end) begin
            r_rx_baud <= '0;
            if (w_rx_bit) r_rx_state <= ST_IDLE;
            else          r_rx_wait  <= 1'b1;
          end else begin
            r_rx_baud <= r_rx_baud + 1'b1;
          end
        end
      endcase
    end
  end

  serial_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_rx_push),
    .pop   (serial_rden_in),
    .din   (r_rx_shift),
    .head  (serial_rdata_out),
    .full  (w_rx_full),
    .empty (w_rx_empty)
  );

  assign serial_valid_out = !w_rx_empty;

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tx_ovf  <= 1'b0;
      r_rx_ovr  <= 1'b0;
      r_rx_ferr <= 1'b0;
    end else begin
      if (serial_wren_in && w_tx_full)  r_tx_ovf  <= 1'b1;
      if (w_rx_push && w_rx_full)       r_rx_ovr  <= 1'b1;
      if (w_rx_stop_smp && !w_rx_bit)   r_rx_ferr <= 1'b1;
    end
  end

  assign tx_overflow_out  = r_tx_ovf;
  assign rx_overrun_out   = r_rx_ovr;
  assign rx_frame_err_out = r_rx_ferr;

endmodule

// File: tb/tb_serial_port_responder.sv
// Directed bench for serial_port_responder (CLKS_PER_BIT=16, FIFO_DEPTH=8).
module tb_serial_port_responder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] serial_wdata_in = 8'h00;
  logic       serial_wren_in = 1'b0;
  logic       serial_rden_in = 1'b0;
  logic       uart_rx_in = 1'b1;
`ifdef SERIAL_LOOPBACK_EN
  logic       loopback_in = 1'b0;
`endif
  logic       serial_ready_out;
  logic [7:0] serial_rdata_out;
  logic       serial_valid_out;
  logic       uart_tx_out;
  logic       tx_overflow_out;
  logic       rx_overrun_out;
  logic       rx_frame_err_out;

  int total = 0;
  int bad   = 0;

  serial_port_responder #(.CLKS_PER_BIT(16), .FIFO_DEPTH(8)) dut (
    .clock            (clock),
    .reset            (reset),
`ifdef SERIAL_LOOPBACK_EN
    .loopback_in      (loopback_in),
`endif
    .serial_wdata_in  (serial_wdata_in),
    .serial_wren_in   (serial_wren_in),
    .serial_ready_out (serial_ready_out),
    .serial_rden_in   (serial_rden_in),
    .serial_rdata_out (serial_rdata_out),
    .serial_valid_out (serial_valid_out),
    .uart_rx_in       (uart_rx_in),
    .uart_tx_out      (uart_tx_out),
    .tx_overflow_out  (tx_overflow_out),
    .rx_overrun_out   (rx_overrun_out),
    .rx_frame_err_out (rx_frame_err_out)
  );

  always #5 clock = ~clock;

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic write_byte(input logic [7:0] b);
    serial_wdata_in = b;
    serial_wren_in  = 1'b1;
    step(1);
    serial_wren_in  = 1'b0;
  endtask

  task automatic read_pop();
    serial_rden_in = 1'b1;
    step(1);
    serial_rden_in = 1'b0;
  endtask

  // Drive one 8N1 frame (16 clocks per bit), then 4 clocks of idle-high
  task automatic send_frame(input logic [7:0] b, input logic stopb);
    uart_rx_in = 1'b0;
    step(16);
    for (int i = 0; i < 8; i++) begin
      uart_rx_in = b[i];
      step(16);
    end
    uart_rx_in = stopb;
    step(16);
    uart_rx_in = 1'b1;
    step(4);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    total++; if (uart_tx_out !== 1'b1)      begin $display("FAIL reset_tx: got %b want 1", uart_tx_out); bad++; end
    total++; if (serial_ready_out !== 1'b1) begin $display("FAIL reset_ready: got %b want 1", serial_ready_out); bad++; end
    total++; if (serial_valid_out !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", serial_valid_out); bad++; end
    total++; if (serial_rdata_out !== 8'h00) begin $display("FAIL reset_rdata: got %h want 00", serial_rdata_out); bad++; end
    total++; if ({tx_overflow_out, rx_overrun_out, rx_frame_err_out} !== 3'b000)
      begin $display("FAIL reset_flags: got %b want 000", {tx_overflow_out, rx_overrun_out, rx_frame_err_out}); bad++; end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_tx_byte();
    logic [7:0] exp;
    int n;
    int low;
    exp = 8'hA5;
    write_byte(exp);
    n = 0;
    while (uart_tx_out !== 1'b0 && n < 10) begin step(1); n++; end
    total++;
    if (uart_tx_out !== 1'b0) begin
      $display("FAIL tx_start_timeout: line got %b want 0 within 10 cycles", uart_tx_out); bad++;
    end else begin
      low = 0;
      while (uart_tx_out === 1'b0 && low < 40) begin step(1); low++; end
      total++; if (low != 16) begin $display("FAIL tx_start_len: got %0d cycles want 16", low); bad++; end
      step(8);
      for (int i = 0; i < 8; i++) begin
        total++;
        if (uart_tx_out !== exp[i]) begin $display("FAIL tx_bit%0d: got %b want %b", i, uart_tx_out, exp[i]); bad++; end
        step(16);
      end
      total++; if (uart_tx_out !== 1'b1) begin $display("FAIL tx_stop: got %b want 1", uart_tx_out); bad++; end
    end
    total++; if (tx_overflow_out !== 1'b0) begin $display("FAIL tx_ovf_clear: got %b want 0", tx_overflow_out); bad++; end
    step(20);
  endtask

  task automatic test_tx_full();
    for (int k = 0; k < 9; k++) begin
      total++;
      if (serial_ready_out !== 1'b1) begin $display("FAIL tx_fill_ready%0d: got %b want 1", k, serial_ready_out); bad++; end
      write_byte(8'(8'h10 + k));
    end
    total++; if (serial_ready_out !== 1'b0) begin $display("FAIL tx_full_ready: got %b want 0", serial_ready_out); bad++; end
    total++; if (tx_overflow_out !== 1'b0)  begin $display("FAIL tx_ovf_early: got %b want 0", tx_overflow_out); bad++; end
    write_byte(8'hEE);
    total++; if (tx_overflow_out !== 1'b1)  begin $display("FAIL tx_ovf_set: got %b want 1", tx_overflow_out); bad++; end
    step(5);
    total++; if (tx_overflow_out !== 1'b1)  begin $display("FAIL tx_ovf_sticky: got %b want 1", tx_overflow_out); bad++; end
    apply_reset();
    total++; if (tx_overflow_out !== 1'b0)  begin $display("FAIL tx_ovf_reset: got %b want 0", tx_overflow_out); bad++; end
    total++; if (serial_ready_out !== 1'b1) begin $display("FAIL tx_ready_reset: got %b want 1", serial_ready_out); bad++; end
  endtask

  task automatic test_rx_byte();
    send_frame(8'h3C, 1'b1);
    total++; if (serial_valid_out !== 1'b1)  begin $display("FAIL rx_valid: got %b want 1", serial_valid_out); bad++; end
    total++; if (serial_rdata_out !== 8'h3C) begin $display("FAIL rx_data: got %h want 3c", serial_rdata_out); bad++; end
    read_pop();
    total++; if (serial_valid_out !== 1'b0)  begin $display("FAIL rx_pop_valid: got %b want 0", serial_valid_out); bad++; end
    read_pop();
    total++; if (serial_valid_out !== 1'b0)  begin $display("FAIL rx_empty_pop: got %b want 0", serial_valid_out); bad++; end
  endtask

  task automatic test_rx_overrun();
    for (int k = 0; k < 8; k++) send_frame(8'(8'h60 + k), 1'b1);
    total++; if (rx_overrun_out !== 1'b0) begin $display("FAIL rx_ovr_early: got %b want 0", rx_overrun_out); bad++; end
    send_frame(8'h68, 1'b1);
    total++; if (rx_overrun_out !== 1'b1) begin $display("FAIL rx_ovr_set: got %b want 1", rx_overrun_out); bad++; end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (serial_valid_out !== 1'b1 || serial_rdata_out !== 8'(8'h60 + k)) begin
        $display("FAIL rx_ovr_read%0d: got v=%b d=%h want v=1 d=%h", k, serial_valid_out, serial_rdata_out, 8'(8'h60 + k)); bad++;
      end
      read_pop();
    end
    total++; if (serial_valid_out !== 1'b0) begin $display("FAIL rx_ovr_drained: got %b want 0", serial_valid_out); bad++; end
  endtask

  task automatic test_rx_frame_err();
    total++; if (rx_frame_err_out !== 1'b0) begin $display("FAIL rx_ferr_early: got %b want 0", rx_frame_err_out); bad++; end
    send_frame(8'hF0, 1'b0);
    total++; if (serial_valid_out !== 1'b0) begin $display("FAIL rx_ferr_nopush: got %b want 0", serial_valid_out); bad++; end
    total++; if (rx_frame_err_out !== 1'b1) begin $display("FAIL rx_ferr_set: got %b want 1", rx_frame_err_out); bad++; end
    send_frame(8'h55, 1'b1);
    total++; if (serial_valid_out !== 1'b1 || serial_rdata_out !== 8'h55) begin
      $display("FAIL rx_after_ferr: got v=%b d=%h want v=1 d=55", serial_valid_out, serial_rdata_out); bad++;
    end
    read_pop();
  endtask

  task automatic test_reset_mid_frame();
    int n;
    write_byte(8'h00);
    write_byte(8'h00);
    n = 0;
    while (uart_tx_out !== 1'b0 && n < 10) begin step(1); n++; end
    step(40);
    total++; if (uart_tx_out !== 1'b0) begin $display("FAIL mid_data_low: got %b want 0", uart_tx_out); bad++; end
    reset = 1'b1;
    #1;
    total++; if (uart_tx_out !== 1'b1)      begin $display("FAIL mid_reset_tx: got %b want 1", uart_tx_out); bad++; end
    total++; if (serial_ready_out !== 1'b1) begin $display("FAIL mid_reset_ready: got %b want 1", serial_ready_out); bad++; end
    step(2);
    reset = 1'b0;
    step(40);
    total++; if (uart_tx_out !== 1'b1)      begin $display("FAIL mid_reset_idle: got %b want 1", uart_tx_out); bad++; end
    total++; if (serial_valid_out !== 1'b0) begin $display("FAIL mid_reset_valid: got %b want 0", serial_valid_out); bad++; end
  endtask

`ifdef SERIAL_LOOPBACK_EN
  task automatic test_loopback();
    int n;
    loopback_in = 1'b1;
    step(2);
    write_byte(8'h81);
    step(20);
    total++; if (uart_tx_out !== 1'b1) begin $display("FAIL lb_tx_held: got %b want 1", uart_tx_out); bad++; end
    n = 0;
    while (serial_valid_out !== 1'b1 && n < 400) begin step(1); n++; end
    total++; if (serial_valid_out !== 1'b1 || serial_rdata_out !== 8'h81) begin
      $display("FAIL lb_data: got v=%b d=%h want v=1 d=81", serial_valid_out, serial_rdata_out); bad++;
    end
    read_pop();
    step(20);
    loopback_in = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_tx_byte();
    test_tx_full();
    test_rx_byte();
    test_rx_overrun();
    test_rx_frame_err();
    test_reset_mid_frame();
`ifdef SERIAL_LOOPBACK_EN
    test_loopback();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
